// File: rtl/vliw_scoreboard_if.sv
// Issue-bundle and operand-lookup signals between decode and the VLIW scoreboard.
// Decode is the master; the scoreboard is the slave.
interface vliw_scoreboard_if #(
    parameter int LANES = 2,
    parameter int NREGS = 8,
    parameter int DEPTH = 3
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                  iss_valid;
    logic [LANES*AW-1:0]   iss_src_a;
    logic [LANES*AW-1:0]   iss_src_b;
    logic [LANES*AW-1:0]   iss_dst;
    logic [LANES-1:0]      iss_we;
    logic [LANES-1:0]      iss_load;
    logic                  flush;
    logic                  stall;
    logic [LANES*SW-1:0]   fwd_sel_a;
    logic [LANES*SW-1:0]   fwd_sel_b;
    logic [LANES*LW-1:0]   fwd_lane_a;
    logic [LANES*LW-1:0]   fwd_lane_b;
    logic                  waw_conflict;

    modport master (
        output iss_valid, iss_src_a, iss_src_b, iss_dst, iss_we, iss_load, flush,
        input  stall, fwd_sel_a, fwd_sel_b, fwd_lane_a, fwd_lane_b, waw_conflict
    );

    modport slave (
        input  iss_valid, iss_src_a, iss_src_b, iss_dst, iss_we, iss_load, flush,
        output stall, fwd_sel_a, fwd_sel_b, fwd_lane_a, fwd_lane_b, waw_conflict
    );
endinterface

// File: rtl/vliw_scoreboard.sv
// Per-register in-flight producer tracker for a multi-lane VLIW pipeline:
// returns bundle stall and per-operand forwarding stage/lane selects.
module vliw_scoreboard #(
    parameter int LANES    = 2,
    parameter int NREGS    = 8,
    parameter int DEPTH    = 3,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    vliw_scoreboard_if.slave    sb
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [NREGS-1:0]           pend, pend_n;
    logic [NREGS-1:0][SW-1:0]   age,  age_n;
    logic [NREGS-1:0][LW-1:0]   lane, lane_n;
    logic [NREGS-1:0]           ld,   ld_n;

    logic                       hazard_any;
    logic                       waw;
    logic                       stall_w;
    logic                       commit;
    logic [LANES*SW-1:0]        sel_a, sel_b;
    logic [LANES*LW-1:0]        ln_a,  ln_b;

    // A pending producer is always reported; it only becomes a hazard while younger than its latency.
    always_comb begin
        hazard_any = 1'b0;
        sel_a      = '0;
        sel_b      = '0;
        ln_a       = '0;
        ln_b       = '0;
        for (int i = 0; i < LANES; i++) begin
            if (pend[sb.iss_src_a[i*AW +: AW]]) begin
                sel_a[i*SW +: SW] = age[sb.iss_src_a[i*AW +: AW]];
                ln_a[i*LW +: LW]  = lane[sb.iss_src_a[i*AW +: AW]];
                if (age[sb.iss_src_a[i*AW +: AW]] <
                    (ld[sb.iss_src_a[i*AW +: AW]] ? SW'(LOAD_LAT) : SW'(ALU_LAT)))
                    hazard_any = 1'b1;
            end
            if (pend[sb.iss_src_b[i*AW +: AW]]) begin
                sel_b[i*SW +: SW] = age[sb.iss_src_b[i*AW +: AW]];
                ln_b[i*LW +: LW]  = lane[sb.iss_src_b[i*AW +: AW]];
                if (age[sb.iss_src_b[i*AW +: AW]] <
                    (ld[sb.iss_src_b[i*AW +: AW]] ? SW'(LOAD_LAT) : SW'(ALU_LAT)))
                    hazard_any = 1'b1;
            end
        end
    end

    always_comb begin
        waw = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (sb.iss_we[i] && sb.iss_we[j] &&
                    (sb.iss_dst[i*AW +: AW] == sb.iss_dst[j*AW +: AW]))
                    waw = 1'b1;
            end
        end
    end

    assign stall_w         = sb.iss_valid & hazard_any;
    assign commit          = sb.iss_valid & ~stall_w & ~sb.flush;
    assign sb.stall        = stall_w;
    assign sb.waw_conflict = sb.iss_valid & waw;
    assign sb.fwd_sel_a    = sel_a;
    assign sb.fwd_sel_b    = sel_b;
    assign sb.fwd_lane_a   = ln_a;
    assign sb.fwd_lane_b   = ln_b;

    // Age or retire every entry, then let committing lanes overwrite; later lanes win on a shared dst.
    always_comb begin
        pend_n = pend;
        age_n  = age;
        lane_n = lane;
        ld_n   = ld;
        for (int r = 0; r < NREGS; r++) begin
            if (pend[r]) begin
                if ((sb.flush && age[r] == SW'(1)) || age[r] == SW'(DEPTH)) begin
                    pend_n[r] = 1'b0;
                    age_n[r]  = '0;
                    lane_n[r] = '0;
                    ld_n[r]   = 1'b0;
                end else begin
                    age_n[r] = age[r] + SW'(1);
                end
            end
        end
        if (commit) begin
            for (int i = 0; i < LANES; i++) begin
                if (sb.iss_we[i]) begin
                    pend_n[sb.iss_dst[i*AW +: AW]] = 1'b1;
                    age_n[sb.iss_dst[i*AW +: AW]]  = SW'(1);
                    lane_n[sb.iss_dst[i*AW +: AW]] = LW'(i);
                    ld_n[sb.iss_dst[i*AW +: AW]]   = sb.iss_load[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            age  <= '0;
            lane <= '0;
            ld   <= '0;
        end else begin
            pend <= pend_n;
            age  <= age_n;
            lane <= lane_n;
            ld   <= ld_n;
        end
    end
endmodule

// File: tb/tb_vliw_scoreboard.sv
// Directed bench for vliw_scoreboard with a producer-list reference model
// compared against the DUT every cycle.
module tb_vliw_scoreboard;
    localparam int LANES    = 2;
    localparam int NREGS    = 8;
    localparam int DEPTH    = 3;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;

    typedef struct {
        int rg;
        int t;
        int ln;
        bit ld;
    } prod_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_d;
    logic [5:0] src_a_d, src_b_d, dst_d;
    logic [1:0] we_d, load_d;
    logic       flush_d;

    int    tests_run    = 0;
    int    tests_failed = 0;
    prod_t prods[$];
    prod_t nq[$];
    int    now_edge     = 0;

    vliw_scoreboard_if #(.LANES(LANES), .NREGS(NREGS), .DEPTH(DEPTH)) sbif ();

    assign sbif.iss_valid = valid_d;
    assign sbif.iss_src_a = src_a_d;
    assign sbif.iss_src_b = src_b_d;
    assign sbif.iss_dst   = dst_d;
    assign sbif.iss_we    = we_d;
    assign sbif.iss_load  = load_d;
    assign sbif.flush     = flush_d;

    vliw_scoreboard #(
        .LANES(LANES), .NREGS(NREGS), .DEPTH(DEPTH),
        .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Newest live producer of s decides the operand: its age is edges elapsed since issue plus one.
    function automatic void model_lookup(input int s, output bit hz, output int sel, output int ln);
        int best;
        int ag;
        best = -1;
        hz   = 1'b0;
        sel  = 0;
        ln   = 0;
        foreach (prods[k])
            if (prods[k].rg == s && (best < 0 || prods[k].t >= prods[best].t)) best = k;
        if (best >= 0) begin
            ag = now_edge - prods[best].t + 1;
            if (ag >= 1 && ag <= DEPTH) begin
                sel = ag;
                ln  = prods[best].ln;
                hz  = ag < (prods[best].ld ? LOAD_LAT : ALU_LAT);
            end
        end
    endfunction

    function automatic bit model_stall();
        bit hz;
        int sel, ln;
        bit any;
        any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            model_lookup(int'(src_a_d[i*3 +: 3]), hz, sel, ln);
            any |= hz;
            model_lookup(int'(src_b_d[i*3 +: 3]), hz, sel, ln);
            any |= hz;
        end
        return valid_d && any;
    endfunction

    function automatic bit model_waw();
        bit w;
        w = 1'b0;
        for (int i = 0; i < LANES; i++)
            for (int j = i + 1; j < LANES; j++)
                if (we_d[i] && we_d[j] && dst_d[i*3 +: 3] == dst_d[j*3 +: 3]) w = 1'b1;
        return valid_d && w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prods.delete();
            now_edge = 0;
        end else begin
            bit commit;
            prod_t p;
            commit = valid_d && !model_stall() && !flush_d;
            nq.delete();
            foreach (prods[k])
                if (!(flush_d && (now_edge - prods[k].t + 1) == 1)) nq.push_back(prods[k]);
            now_edge++;
            prods.delete();
            foreach (nq[k])
                if ((now_edge - nq[k].t + 1) <= DEPTH) prods.push_back(nq[k]);
            if (commit) begin
                for (int i = 0; i < LANES; i++) begin
                    if (we_d[i]) begin
                        nq.delete();
                        foreach (prods[k])
                            if (prods[k].rg != int'(dst_d[i*3 +: 3])) nq.push_back(prods[k]);
                        prods = nq;
                        p.rg = int'(dst_d[i*3 +: 3]);
                        p.t  = now_edge;
                        p.ln = i;
                        p.ld = load_d[i];
                        prods.push_back(p);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit hz;
        int sel, ln;
        check_output("cmp_stall", 32'(sbif.stall), 32'(model_stall()));
        check_output("cmp_waw", 32'(sbif.waw_conflict), 32'(model_waw()));
        for (int i = 0; i < LANES; i++) begin
            model_lookup(int'(src_a_d[i*3 +: 3]), hz, sel, ln);
            if (!hz) begin
                check_output($sformatf("cmp_sel_a%0d", i), 32'(sbif.fwd_sel_a[i*2 +: 2]), 32'(sel));
                check_output($sformatf("cmp_lane_a%0d", i), 32'(sbif.fwd_lane_a[i]), 32'(ln));
            end
            model_lookup(int'(src_b_d[i*3 +: 3]), hz, sel, ln);
            if (!hz) begin
                check_output($sformatf("cmp_sel_b%0d", i), 32'(sbif.fwd_sel_b[i*2 +: 2]), 32'(sel));
                check_output($sformatf("cmp_lane_b%0d", i), 32'(sbif.fwd_lane_b[i]), 32'(ln));
            end
        end
    end

    task automatic apply_stimulus(input logic v, input logic [2:0] a0, a1, b0, b1, d0, d1,
                                  input logic [1:0] we, ld, input logic fl);
        @(posedge clk);
        #1;
        valid_d = v;
        src_a_d = {a1, a0};
        src_b_d = {b1, b0};
        dst_d   = {d1, d0};
        we_d    = we;
        load_d  = ld;
        flush_d = fl;
        #3;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_d = 1'b0;
        src_a_d = '0;
        src_b_d = '0;
        dst_d   = '0;
        we_d    = '0;
        load_d  = '0;
        flush_d = 1'b0;

        repeat (2) @(posedge clk);
        #3;
        check_output("rst_stall", 32'(sbif.stall), 0);
        check_output("rst_sel_a", 32'(sbif.fwd_sel_a), 0);
        check_output("rst_sel_b", 32'(sbif.fwd_sel_b), 0);
        check_output("rst_waw", 32'(sbif.waw_conflict), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // ALU producer r3 from lane0 seen by lane1 src_a across its lifetime
        apply_stimulus(1, 0, 0, 0, 0, 3, 0, 2'b01, 2'b00, 0);
        apply_stimulus(1, 0, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("alu_sel_c1", 32'(sbif.fwd_sel_a[3:2]), 1);
        check_output("alu_stall_c1", 32'(sbif.stall), 0);
        apply_stimulus(1, 0, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("alu_sel_c2", 32'(sbif.fwd_sel_a[3:2]), 2);
        apply_stimulus(1, 0, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("alu_sel_c3", 32'(sbif.fwd_sel_a[3:2]), 3);
        check_output("alu_lane_c3", 32'(sbif.fwd_lane_a[1]), 0);
        apply_stimulus(1, 0, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("alu_sel_c4", 32'(sbif.fwd_sel_a[3:2]), 0);
        idle(4);

        // Load r5 on lane1; the stalled consumer bundle also writes r6 and must not commit early
        apply_stimulus(1, 0, 0, 0, 0, 0, 5, 2'b10, 2'b10, 0);
        apply_stimulus(1, 0, 0, 5, 0, 6, 0, 2'b01, 2'b00, 0);
        check_output("ld_stall_c1", 32'(sbif.stall), 1);
        apply_stimulus(1, 0, 0, 5, 0, 6, 0, 2'b01, 2'b00, 0);
        check_output("ld_stall_c2", 32'(sbif.stall), 0);
        check_output("ld_sel_b_c2", 32'(sbif.fwd_sel_b[1:0]), 2);
        check_output("ld_lane_b_c2", 32'(sbif.fwd_lane_b[0]), 1);
        apply_stimulus(1, 0, 6, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("held_r6_sel", 32'(sbif.fwd_sel_a[3:2]), 1);
        idle(4);

        // Both lanes write r2; lane1 (load) wins
        apply_stimulus(1, 0, 0, 0, 0, 2, 2, 2'b11, 2'b10, 0);
        check_output("waw_flag", 32'(sbif.waw_conflict), 1);
        apply_stimulus(1, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("waw_stall", 32'(sbif.stall), 1);
        apply_stimulus(1, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("waw_lane", 32'(sbif.fwd_lane_a[0]), 1);
        check_output("waw_sel", 32'(sbif.fwd_sel_a[1:0]), 2);
        idle(4);

        // Flush squashes age-1 r4 and the concurrent r6 bundle
        apply_stimulus(1, 0, 0, 0, 0, 4, 0, 2'b01, 2'b00, 0);
        apply_stimulus(1, 0, 0, 0, 0, 6, 0, 2'b01, 2'b00, 1);
        apply_stimulus(1, 4, 0, 6, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("flush_sel_a", 32'(sbif.fwd_sel_a[1:0]), 0);
        check_output("flush_sel_b", 32'(sbif.fwd_sel_b[1:0]), 0);
        check_output("flush_stall", 32'(sbif.stall), 0);
        idle(4);

        // Flush during a stall: load r5 is squashed and the r1 bundle never commits
        apply_stimulus(1, 0, 0, 0, 0, 0, 5, 2'b10, 2'b10, 0);
        apply_stimulus(1, 5, 0, 0, 0, 1, 0, 2'b01, 2'b00, 1);
        check_output("fstall_stall", 32'(sbif.stall), 1);
        apply_stimulus(1, 5, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("fstall_sel_a", 32'(sbif.fwd_sel_a[1:0]), 0);
        check_output("fstall_sel_b", 32'(sbif.fwd_sel_b[1:0]), 0);
        idle(4);

        // iss_we=0 never creates entries; the newer of two r7 producers wins
        apply_stimulus(1, 0, 0, 0, 0, 7, 7, 2'b00, 2'b00, 0);
        apply_stimulus(1, 7, 0, 0, 0, 7, 0, 2'b01, 2'b00, 0);
        check_output("nowe_sel", 32'(sbif.fwd_sel_a[1:0]), 0);
        apply_stimulus(1, 7, 0, 0, 0, 0, 7, 2'b10, 2'b00, 0);
        check_output("r7_old_sel", 32'(sbif.fwd_sel_a[1:0]), 1);
        check_output("r7_old_lane", 32'(sbif.fwd_lane_a[0]), 0);
        apply_stimulus(1, 7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("r7_new_sel", 32'(sbif.fwd_sel_a[1:0]), 1);
        check_output("r7_new_lane", 32'(sbif.fwd_lane_a[0]), 1);
        idle(4);

        // Asynchronous reset with three producers in flight
        apply_stimulus(1, 0, 0, 0, 0, 1, 2, 2'b11, 2'b00, 0);
        apply_stimulus(1, 0, 0, 0, 0, 3, 0, 2'b01, 2'b00, 0);
        apply_stimulus(1, 1, 2, 3, 0, 0, 0, 2'b00, 2'b00, 0);
        check_output("pre_rst_sel_a", 32'(sbif.fwd_sel_a), 32'b1010);
        check_output("pre_rst_sel_b", 32'(sbif.fwd_sel_b[1:0]), 1);
        rst_n = 1'b0;
        #2;
        check_output("mid_rst_sel_a", 32'(sbif.fwd_sel_a), 0);
        check_output("mid_rst_sel_b", 32'(sbif.fwd_sel_b), 0);
        check_output("mid_rst_lane_a", 32'(sbif.fwd_lane_a), 0);
        check_output("mid_rst_stall", 32'(sbif.stall), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
